// File: rtl/instr_ctrl_pkg.sv
// instr_ctrl_pkg: shared types and constants for the instruction controller.
//   state_t   - controller FSM states
//   OPC_*     - opcode field values (IR[15:13])
//   OP_*      - op field values (IR[12:11]) for ALU and MOV instructions
package instr_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_IMM,
        S_WR_REG
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational field extraction from the latched IR.
//   ir      in  16  latched instruction
//   opcode  out  3  IR[15:13]
//   op      out  2  IR[12:11]
//   rn/rd/rm out 3  register fields IR[10:8], IR[7:5], IR[2:0]
//   shift   out  2  IR[4:3]
//   aluop   out  2  IR[12:11]
//   sximm8  out 16  sign-extended IR[7:0]
//   sximm5  out 16  sign-extended IR[4:0]
module instr_decoder (
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign shift  = ir[4:3];
    assign aluop  = ir[12:11];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/instr_controller.sv
// instr_controller: latches one instruction and sequences regfile reads/writes
// and datapath load enables over several cycles (Moore FSM, registered outputs).
//   clk, reset        clock, async active-high reset (forces WAIT)
//   s, in             start strobe and instruction, sampled only in WAIT
//   w                 high only in WAIT
//   readnum/writenum  regfile selects; write = regfile write enable
//   loada/b/c/s       load enables; asel/bsel/vsel datapath mux selects
//   shift/aluop/sximm8/sximm5  continuous decodes of IR
// Build option: define INSTR_CONTROLLER_CMP_EN to support CMP (opcode 101,
// op 01). Without it that encoding is illegal and loads is tied to 0.
module instr_controller
    import instr_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_t      state, nxt;
    logic [15:0] ir;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op;

    instr_decoder u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .shift  (shift),
        .aluop  (aluop),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    logic cmp_ok;
`ifdef INSTR_CONTROLLER_CMP_EN
    assign cmp_ok = 1'b1;
`else
    assign cmp_ok = 1'b0;
`endif

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_two_src;
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP) && cmp_ok;
    assign is_mvn     = is_alu && (op == OP_MVN);
    // Instructions that read both Rn and Rm.
    assign is_two_src = is_alu && ((op == OP_ADD) || (op == OP_AND) || is_cmp);

    always_comb begin
        nxt = S_WAIT;
        case (state)
            S_WAIT:   nxt = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (is_mov_imm)                nxt = S_WR_IMM;
                else if (is_mov_reg || is_mvn) nxt = S_GET_B;
                else if (is_two_src)           nxt = S_GET_A;
                else                           nxt = S_WAIT;
            end
            S_GET_A:  nxt = S_GET_B;
            S_GET_B:  nxt = S_EXEC;
            S_EXEC:   nxt = is_cmp ? S_WAIT : S_WR_REG;
            default:  nxt = S_WAIT;
        endcase
    end

    // Outputs are registered from the next state so each one is a clean
    // function of the state it is presented in. IR is stable in every state
    // whose outputs depend on it (it only changes on the WAIT -> DECODE edge).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_WAIT;
            ir       <= '0;
            w        <= 1'b1;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            asel     <= 1'b0;
            vsel     <= 1'b0;
`ifdef INSTR_CONTROLLER_CMP_EN
            loads    <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == S_WAIT && s) ir <= in;
            w        <= (nxt == S_WAIT);
            readnum  <= (nxt == S_GET_A) ? rn : (nxt == S_GET_B) ? rm : 3'd0;
            writenum <= (nxt == S_WR_IMM) ? rn : (nxt == S_WR_REG) ? rd : 3'd0;
            write    <= (nxt == S_WR_IMM) || (nxt == S_WR_REG);
            loada    <= (nxt == S_GET_A);
            loadb    <= (nxt == S_GET_B);
            loadc    <= (nxt == S_EXEC);
            asel     <= (nxt == S_EXEC) && is_mov_reg;
            vsel     <= (nxt == S_WR_IMM);
`ifdef INSTR_CONTROLLER_CMP_EN
            loads    <= (nxt == S_EXEC) && is_cmp;
`endif
        end
    end

`ifndef INSTR_CONTROLLER_CMP_EN
    assign loads = 1'b0;
`endif

    // B input always comes from the register path in this instruction set.
    assign bsel = 1'b0;

endmodule

// File: tb/tb_instr_controller.sv
module tb_instr_controller;

`ifdef INSTR_CONTROLLER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8, sximm5;

    instr_controller dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .aluop(aluop), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] rn;
        logic [2:0] wn;
        logic       wr, la, lb, lc, ls, as, bs, vs;
    } ctl_t;

    int   errs = 0, checks = 0;
    ctl_t exp_q[$];
    ctl_t idle_ctl;
    logic [15:0] last_ir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t ctl_now();
        ctl_t c;
        c = '{w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel};
        return c;
    endfunction

    // Decoded fields computed arithmetically from the instruction word.
    task automatic chk_dec(input string tag, input logic [15:0] i);
        logic [15:0] e8, e5;
        e8 = 16'(i[7:0]) - (i[7] ? 16'd256 : 16'd0);
        e5 = 16'(i[4:0]) - (i[4] ? 16'd32 : 16'd0);
        chk({tag, ".imm"}, {sximm8, sximm5}, {e8, e5});
        chk({tag, ".fld"}, 32'({shift, aluop}), 32'({i[4:3], i[12:11]}));
    endtask

    // Reference: the per-cycle control outputs from DECODE until return to WAIT.
    function automatic void build_exp(input logic [15:0] i);
        ctl_t c;
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op;
        bit mov_imm, mov_reg, alu, cmp, legal;
        opc = i[15:13]; op = i[12:11];
        rn = i[10:8]; rd = i[7:5]; rm = i[2:0];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101) && (op != 2'b01 || CMP_EN);
        cmp     = alu && (op == 2'b01);
        legal   = mov_reg || alu;
        exp_q.delete();
        c = '0; exp_q.push_back(c);                 // DECODE
        if (mov_imm) begin
            c = '0; c.wn = rn; c.wr = 1; c.vs = 1; exp_q.push_back(c);
        end else if (legal) begin
            if (alu && op != 2'b11) begin
                c = '0; c.rn = rn; c.la = 1; exp_q.push_back(c);
            end
            c = '0; c.rn = rm; c.lb = 1; exp_q.push_back(c);
            c = '0; c.lc = 1; c.as = mov_reg; c.ls = cmp; exp_q.push_back(c);
            if (!cmp) begin
                c = '0; c.wn = rd; c.wr = 1; exp_q.push_back(c);
            end
        end
    endfunction

    task automatic run_instr(input logic [15:0] i, input string nm);
        build_exp(i);
        @(negedge clk); in = i; s = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s.c%0d", nm, k), 32'(ctl_now()), 32'(exp_q[k]));
            if (k == 0) chk_dec(nm, i);
            s  = 1'($urandom_range(0, 1));   // ignored outside WAIT
            in = 16'($urandom);
            @(posedge clk); #1;
        end
        s = 1'b0;
        chk({nm, ".done"}, 32'(ctl_now()), 32'(idle_ctl));
        last_ir = i;
        // idle a little with garbage on in; IR must hold
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            @(negedge clk); in = 16'($urandom);
            @(posedge clk); #1;
            chk({nm, ".idle"}, 32'(ctl_now()), 32'(idle_ctl));
            chk_dec({nm, ".idle"}, last_ir);
        end
    endtask

    initial begin
        idle_ctl = '0; idle_ctl.w = 1'b1;
        reset = 1'b0; s = 1'b0; in = '0; last_ir = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst.ctl", 32'(ctl_now()), 32'(idle_ctl));
        chk_dec("rst", 16'h0000);
        @(negedge clk); @(negedge clk); reset = 1'b0;

        run_instr(16'hD105, "movimm5");
        run_instr(16'hA0A1, "add");
        run_instr(16'hA900, "cmp");
        run_instr(16'hD180, "movimm_neg");
        run_instr(16'h0000, "illegal");
        run_instr(16'hC0E3, "movreg");
        run_instr(16'hB8A2, "mvn");
        run_instr(16'hD000, "movimm_boundary"); // zero immediate
        run_instr(16'hD17F, "movimm_max");

        // reset during GET_B of an ADD
        build_exp(16'hA0A1);
        @(negedge clk); in = 16'hA0A1; s = 1'b1;
        @(posedge clk); #1; s = 1'b0;
        chk("rstmid.dec", 32'(ctl_now()), 32'(exp_q[0]));
        @(posedge clk); #1;
        chk("rstmid.geta", 32'(ctl_now()), 32'(exp_q[1]));
        @(posedge clk); #1;
        chk("rstmid.getb", 32'(ctl_now()), 32'(exp_q[2]));
        #2 reset = 1'b1;
        #1;
        chk("rstmid.async", 32'(ctl_now()), 32'(idle_ctl));
        chk_dec("rstmid.async", 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rstmid.hold", 32'(ctl_now()), 32'(idle_ctl));
        end
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rstmid.after", 32'(ctl_now()), 32'(idle_ctl));
        end

        // randomized instruction stream, biased toward the two real opcodes
        for (int n = 0; n < 80; n++) begin
            logic [15:0] i;
            case ($urandom_range(0, 3))
                0:       i = {3'b110, 13'($urandom)};
                1:       i = {3'b101, 13'($urandom)};
                default: i = 16'($urandom);
            endcase
            run_instr(i, $sformatf("rnd%0d_%h", n, i));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
